dmem_stage: RTL and testbench

Memory-stage controller for the 16-bit pipelined processor. It sits directly downstream of the EX/MEM buffer and consumes the ALU result (address), the store data and the MEM-stage read/write strobes. It returns load data to the write-back data selector and drives a valid/ready handshake to a variable-latency data memory. Stores are posted through a small store buffer with load forwarding; a `stall` output freezes the pipeline while a load misses the buffer or the buffer is full.

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_stage_store_buffer.sv | 59 +++++
 rtl/dmem_stage.sv | 83 ++++++++
 tb/tb_dmem_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared defaults and FSM state encoding for the data-memory stage.
package dmem_pkg;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
  localparam int DEF_SB_DEPTH = 2;
  typedef enum logic [2:0] {IDLE, ST_REQ, LD_REQ, LD_WAIT, LD_DONE} dmem_state_t;
endpackage

// File: rtl/dmem_stage_store_buffer.sv
// store_buffer: posted-store FIFO with a parallel address compare returning the youngest match.
module store_buffer #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] pushAddr,
  input  logic [DW-1:0] pushData,
  input  logic          pop,
  input  logic [AW-1:0] lookupAddr,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] headAddr,
  output logic [DW-1:0] headData,
  output logic          hit,
  output logic [DW-1:0] hitData
);
  logic [AW-1:0] addrMem [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;

  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign headAddr = addrMem[head];
  assign headData = dataMem[head];

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end

  always_ff @(posedge clk)
    if (push) begin
      addrMem[tail] <= pushAddr;
      dataMem[tail] <= pushData;
    end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit = 1'b0;
    hitData = '0;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count && addrMem[head + PW'(i)] == lookupAddr) begin
        hit = 1'b1;
        hitData = dataMem[head + PW'(i)];
      end
  end
endmodule

// File: rtl/dmem_stage.sv
// dmem_stage: MEM-stage controller with posted stores, load forwarding and a valid/ready data-memory port.
module dmem_stage
  import dmem_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int SB_DEPTH = DEF_SB_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          dm_req,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  input  logic          dm_gnt,
  input  logic          dm_rvalid,
  input  logic [DW-1:0] dm_rdata
);
  dmem_state_t state, nextState;
  logic [DW-1:0] readReg, hitData, headData;
  logic [AW-1:0] headAddr;
  logic full, empty, hit;
  logic isLoad, loadHit, loadMiss, loadReq, issueRd, push, pop;

  store_buffer #(.AW(AW), .DW(DW), .DEPTH(SB_DEPTH)) sb (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pushAddr(addr),
    .pushData(wdata),
    .pop(pop),
    .lookupAddr(addr),
    .full(full),
    .empty(empty),
    .headAddr(headAddr),
    .headData(headData),
    .hit(hit),
    .hitData(hitData)
  );

  assign isLoad = mem_rd && !mem_wr;
  assign loadHit = isLoad && hit && state != LD_DONE;
  assign loadMiss = isLoad && !hit;
  // A miss seen in IDLE already drives its read, so the request overlaps the first stall cycle.
  assign loadReq = state == IDLE && loadMiss;
  assign issueRd = loadReq || state == LD_REQ;
  assign pop = state == ST_REQ && dm_gnt;
  assign push = mem_wr && (!full || pop);

  assign stall = reset && (issueRd || state == LD_WAIT || (state == ST_REQ && loadMiss)
                 || (mem_wr && full && !pop));
  assign dm_req = reset && (issueRd || state == ST_REQ);
  assign dm_we = reset && state == ST_REQ;
  assign dm_addr = !reset ? '0 : state == ST_REQ ? headAddr : issueRd ? addr : '0;
  assign dm_wdata = (reset && state == ST_REQ) ? headData : '0;
  assign rdata = loadHit ? hitData : readReg;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = loadMiss ? (dm_gnt ? LD_WAIT : LD_REQ) : !empty ? ST_REQ : IDLE;
      ST_REQ:  nextState = dm_gnt ? IDLE : ST_REQ;
      LD_REQ:  nextState = dm_gnt ? LD_WAIT : LD_REQ;
      LD_WAIT: nextState = dm_rvalid ? LD_DONE : LD_WAIT;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;

  always_ff @(posedge clk or negedge reset)
    if (!reset) readReg <= '0;
    else if (state == LD_WAIT && dm_rvalid) readReg <= dm_rdata;
    else if (loadHit) readReg <= hitData;
endmodule

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: directed scenarios then randomized traffic against a queue-and-array memory model.
module tb_dmem_stage;
  localparam int DEPTH = 2;
  typedef struct {logic [15:0] a; logic [15:0] d;} st_t;

  logic clk = 1'b0;
  logic reset, mem_rd, mem_wr, stall, dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [15:0] addr, wdata, rdata, dm_addr, dm_wdata, dm_rdata;
  int nAssert = 0;
  int nFail = 0;
  logic [15:0] refMem [8];
  st_t q[$];
  bit rdPend;
  int rdDly;
  logic [15:0] rdA;

  always #5 clk = ~clk;

  dmem_stage dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  task automatic expectWrite(input string tag, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    idleIn();
    dm_gnt = 1'b0;
    #1;
    while (!dm_req && n < 10) begin
      cyc();
      #1;
      n++;
    end
    chk({tag, "_req"}, dm_req, 1);
    chk({tag, "_we"}, dm_we, 1);
    chk({tag, "_addr"}, dm_addr, a);
    chk({tag, "_wdata"}, dm_wdata, d);
    dm_gnt = 1'b1;
    cyc();
    dm_gnt = 1'b0;
  endtask

  initial begin
    int cnt, op;
    bit done, isSt, isLd, mHit, acc, g;
    logic [15:0] curA, curD, expD;
    reset = 1'b0; idleIn(); addr = '0; wdata = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    #12;
    chk("rst_rdata", rdata, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req", dm_req, 0);
    chk("rst_we", dm_we, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_wdata", dm_wdata, 0);
    cyc(); reset = 1'b1;

    // single store and its held drain request
    cyc(); mem_wr = 1'b1; addr = 16'h0010; wdata = 16'hBEEF; #1;
    chk("st1_stall", stall, 0);
    cyc(); idleIn(); #1;
    chk("st1_bubble", dm_req, 0);
    cyc(); #1;
    chk("st1_req", dm_req, 1);
    chk("st1_we", dm_we, 1);
    chk("st1_addr", dm_addr, 16'h0010);
    chk("st1_wdata", dm_wdata, 16'hBEEF);
    cyc(); #1;
    chk("st1_hold_req", dm_req, 1);
    chk("st1_hold_wdata", dm_wdata, 16'hBEEF);
    dm_gnt = 1'b1; cyc(); dm_gnt = 1'b0; #1;
    chk("st1_done", dm_req, 0);

    // youngest-match forwarding
    cyc(); mem_wr = 1'b1; addr = 16'h0020; wdata = 16'h1111; #1;
    chk("fw_st1_stall", stall, 0);
    cyc(); wdata = 16'h2222; #1;
    chk("fw_st2_stall", stall, 0);
    cyc(); mem_wr = 1'b0; mem_rd = 1'b1; #1;
    chk("fw_rdata", rdata, 16'h2222);
    chk("fw_stall", stall, 0);
    chk("fw_noread", dm_req && !dm_we, 0);
    cyc();
    expectWrite("fw_dr1", 16'h0020, 16'h1111);
    expectWrite("fw_dr2", 16'h0020, 16'h2222);

    // miss with grant in third request cycle, data two cycles later
    mem_rd = 1'b1; addr = 16'h0030; cnt = 0; done = 1'b0;
    for (int i = 1; i <= 20 && !done; i++) begin
      if (i > 1) cyc();
      dm_gnt = (i == 3);
      dm_rvalid = (i == 5);
      dm_rdata = (i == 5) ? 16'h5A5A : 16'h0000;
      #1;
      if (i == 1) begin
        chk("miss_req", dm_req, 1);
        chk("miss_we", dm_we, 0);
        chk("miss_addr", dm_addr, 16'h0030);
      end
      if (stall) cnt++;
      else begin
        done = 1'b1;
        chk("miss_rdata", rdata, 16'h5A5A);
      end
    end
    chk("miss_done", done, 1);
    chk("miss_stall_cycles", cnt, 5);
    cyc(); idleIn(); dm_gnt = 1'b0; dm_rvalid = 1'b0; #1;
    chk("miss_rdata_hold", rdata, 16'h5A5A);

    // full buffer, store accepted in the grant cycle
    cyc(); mem_wr = 1'b1; addr = 16'h0050; wdata = 16'h0001; #1;
    chk("full_st1_stall", stall, 0);
    cyc(); addr = 16'h0051; wdata = 16'h0002; #1;
    chk("full_st2_stall", stall, 0);
    cyc(); addr = 16'h0052; wdata = 16'h0003; #1;
    chk("full_st3_stall", stall, 1);
    cyc(); #1;
    chk("full_st3_stall2", stall, 1);
    cyc(); dm_gnt = 1'b1; #1;
    chk("full_gnt_stall", stall, 0);
    chk("full_gnt_addr", dm_addr, 16'h0050);
    cyc(); dm_gnt = 1'b0; idleIn();
    expectWrite("full_dr2", 16'h0051, 16'h0002);
    expectWrite("full_dr3", 16'h0052, 16'h0003);

    // load miss arriving while a store waits for its grant
    cyc(); mem_wr = 1'b1; addr = 16'h0060; wdata = 16'h0077; #1;
    chk("ldst_st_stall", stall, 0);
    cyc(); idleIn();
    cyc(); mem_rd = 1'b1; addr = 16'h0061; #1;
    chk("ldst_stall", stall, 1);
    chk("ldst_we", dm_we, 1);
    cyc(); dm_gnt = 1'b1; #1;
    chk("ldst_gnt_stall", stall, 1);
    cyc(); dm_gnt = 1'b0; #1;
    chk("ldst_rd_stall", stall, 1);
    chk("ldst_rd_req", dm_req, 1);
    chk("ldst_rd_we", dm_we, 0);
    chk("ldst_rd_addr", dm_addr, 16'h0061);
    dm_gnt = 1'b1;
    cyc(); dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 16'h1234; #1;
    chk("ldst_wait_stall", stall, 1);
    cyc(); dm_rvalid = 1'b0; #1;
    chk("ldst_done_stall", stall, 0);
    chk("ldst_done_rdata", rdata, 16'h1234);
    cyc(); idleIn();

    // reset in the middle of a load
    mem_wr = 1'b1; addr = 16'h0070; wdata = 16'h0099; #1;
    chk("rl_st_stall", stall, 0);
    cyc(); mem_wr = 1'b0; mem_rd = 1'b1; addr = 16'h0071; #1;
    chk("rl_req", dm_req, 1);
    chk("rl_we", dm_we, 0);
    dm_gnt = 1'b1;
    cyc(); dm_gnt = 1'b0; #1;
    chk("rl_wait_stall", stall, 1);
    reset = 1'b0; #1;
    chk("rl_rst_req", dm_req, 0);
    chk("rl_rst_stall", stall, 0);
    addr = 16'h0070; #1;
    chk("rl_rst_nohit", rdata, 0);
    cyc(); reset = 1'b1; mem_rd = 1'b0; dm_rvalid = 1'b1; dm_rdata = 16'hDEAD; #1;
    chk("rl_post_req", dm_req, 0);
    chk("rl_post_stall", stall, 0);
    cyc(); dm_rvalid = 1'b0; #1;
    chk("rl_rvalid_ignored", rdata, 0);
    chk("rl_no_drain", dm_req, 0);
    cyc(); mem_rd = 1'b1; addr = 16'h0070; #1;
    chk("rl_fifo_cleared", stall, 1);
    chk("rl_fifo_cleared_we", dm_we, 0);

    // randomized traffic against the model
    reset = 1'b0; idleIn(); #1;
    for (int i = 0; i < 8; i++) refMem[i] = 16'($urandom);
    q.delete(); rdPend = 1'b0; rdDly = 0; rdA = '0;
    cyc(); reset = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op = $urandom_range(0, 9);
      isSt = op < 5 || op == 9;
      isLd = op >= 5 && op < 9;
      curA = 16'h0040 + 16'($urandom_range(0, 7));
      curD = 16'($urandom);
      mHit = 1'b0;
      expD = refMem[curA[2:0]];
      foreach (q[j]) if (q[j].a == curA) begin mHit = 1'b1; expD = q[j].d; end
      acc = 1'b0; cnt = 0;
      while (!acc && cnt < 64) begin
        cyc();
        mem_wr = isSt; mem_rd = isLd || op == 9; addr = curA; wdata = curD;
        if (rdPend && rdDly == 0) begin
          dm_rvalid = 1'b1; dm_rdata = refMem[rdA[2:0]]; rdPend = 1'b0;
        end else begin
          dm_rvalid = 1'b0; dm_rdata = 16'($urandom);
          if (rdPend) rdDly--;
        end
        #1;
        g = dm_req && ($urandom_range(0, 2) == 0);
        dm_gnt = g;
        if (dm_req && dm_we) begin
          chk("rnd_wr_pending", q.size() > 0, 1);
          if (q.size() > 0) begin
            chk("rnd_wr_addr", dm_addr, q[0].a);
            chk("rnd_wr_data", dm_wdata, q[0].d);
          end
        end
        if (dm_req && !dm_we) begin
          chk("rnd_rd_is_miss", isLd && !mHit, 1);
          chk("rnd_rd_addr", dm_addr, curA);
          chk("rnd_one_read", rdPend, 0);
        end
        #1;
        if (isSt && q.size() < DEPTH) chk("rnd_st_nostall", stall, 0);
        if (isLd && mHit) chk("rnd_hit_nostall", stall, 0);
        if (g && dm_we && q.size() > 0) begin
          refMem[q[0].a[2:0]] = q[0].d;
          q.pop_front();
        end
        if (g && !dm_we) begin
          rdPend = 1'b1; rdA = dm_addr; rdDly = $urandom_range(0, 2);
        end
        if (!stall) begin
          acc = 1'b1;
          if (isSt) q.push_back('{curA, curD});
          if (isLd) chk("rnd_load_data", rdata, expD);
        end
        cnt++;
      end
      chk("rnd_progress", acc, 1);
    end
    cyc(); idleIn(); dm_gnt = 1'b0; dm_rvalid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
